// File: rtl/t_ff_divider.sv
// t_ff_divider: enable-gated programmable toggle divider.
// Produces a divided square wave q, a one-cycle pulse on every q toggle,
// and an optional one-hot quadrant indicator on phase.
// Optional feature macro: T_FF_DIVIDER_PHASE_EN (phase logic compiled in when defined,
// otherwise phase is tied to 4'b0000).
module t_ff_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t,
  input  logic [WIDTH-1:0] div,
  output logic             q,
  output logic             pulse,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       phase
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_r_q, div_r_d;
  logic             q_q, q_d;
  logic             pulse_q, pulse_d;

  // Next-state: count enabled cycles up to the latched divisor, toggle and strobe on wrap.
  always_comb begin
    cnt_d   = cnt_q;
    div_r_d = div_r_q;
    q_d     = q_q;
    pulse_d = 1'b0;
    if (t) begin
      if (cnt_q == div_r_q) begin
        cnt_d   = '0;
        q_d     = ~q_q;
        pulse_d = 1'b1;
        div_r_d = div;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset that also reloads the divisor.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      div_r_q <= div;
      q_q     <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_r_q <= div_r_d;
      q_q     <= q_d;
      pulse_q <= pulse_d;
    end
  end

  assign q     = q_q;
  assign pulse = pulse_q;
  assign count = cnt_q;

`ifdef T_FF_DIVIDER_PHASE_EN
  logic       upper;
  logic [1:0] idx;

  // Quadrant decode: q selects the half period, the counter position selects lower/upper half.
  always_comb begin
    upper = (cnt_q > (div_r_q >> 1));
    idx   = {q_q, upper};
    phase = 4'b0001 << idx;
  end
`else
  assign phase = 4'b0000;
`endif

endmodule

// File: tb/tb_t_ff_divider.sv
// Self-checking bench for t_ff_divider: directed scenarios plus randomized
// stimulus compared against an elapsed-cycle reference model.
module tb_t_ff_divider;

  logic       clk;
  logic       reset;
  logic       t;
  logic [7:0] div;
  logic       q;
  logic       pulse;
  logic [7:0] count;
  logic [3:0] phase;

  logic       reset4;
  logic       t4;
  logic [3:0] div4;
  logic       q4;
  logic       pulse4;
  logic [3:0] count4;
  logic [3:0] phase4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: enabled edges elapsed in the current half period and its length.
  int m_half    = 1;
  int m_elapsed = 0;
  bit m_q       = 0;
  bit m_pulse   = 0;

  t_ff_divider #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .t(t), .div(div),
    .q(q), .pulse(pulse), .count(count), .phase(phase)
  );

  t_ff_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .t(t4), .div(div4),
    .q(q4), .pulse(pulse4), .count(count4), .phase(phase4)
  );

  // Free-running clock shared by both instances.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step(input bit r, input bit tt, input logic [7:0] d);
    if (!r) begin
      m_elapsed = 0;
      m_q       = 0;
      m_pulse   = 0;
      m_half    = int'(d) + 1;
    end else if (tt) begin
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == m_half) begin
        m_elapsed = 0;
        m_q       = !m_q;
        m_pulse   = 1;
        m_half    = int'(d) + 1;
      end else begin
        m_pulse = 0;
      end
    end else begin
      m_pulse = 0;
    end
  endtask

  function automatic logic [3:0] model_phase();
`ifdef T_FF_DIVIDER_PHASE_EN
    int idx;
    idx = (m_q ? 2 : 0) + ((m_elapsed > (m_half - 1) / 2) ? 1 : 0);
    return 4'(1 << idx);
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_q, m_pulse, 8'(m_elapsed), model_phase()};
  endfunction

  task automatic tick();
    model_step(reset, t, div);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; t = 1'b1; div = 8'd3;
    tick(); tick();
    n_cmp++;
    if ({q, pulse, count} !== 10'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state got %b want %b", {q, pulse, count}, 10'd0);
    end
    n_cmp++;
    if ({q, pulse, count, phase} !== model_vec()) begin
      n_err++;
      $display("[TB] FAIL reset_model got %h want %h", {q, pulse, count, phase}, model_vec());
    end
  endtask

  task automatic test_div3();
    reset = 1'b0; t = 1'b0; div = 8'd3;
    tick();
    reset = 1'b1; t = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++;
      if ({q, pulse, count} !== {1'((i / 4) % 2), (i % 4 == 0), 8'(i % 4)}) begin
        n_err++;
        $display("[TB] FAIL div3_seq edge %0d got q=%b p=%b c=%0d want q=%0d p=%0d c=%0d",
                 i, q, pulse, count, (i / 4) % 2, (i % 4 == 0), i % 4);
      end
      n_cmp++;
      if ({q, pulse, count, phase} !== model_vec()) begin
        n_err++;
        $display("[TB] FAIL div3_model edge %0d got %h want %h", i, {q, pulse, count, phase}, model_vec());
      end
    end
  endtask

  task automatic test_div0_hold();
    reset = 1'b0; t = 1'b0; div = 8'd0;
    tick();
    reset = 1'b1; t = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if ({q, pulse, count} !== {1'(i % 2), 1'b1, 8'd0}) begin
        n_err++;
        $display("[TB] FAIL div0_run edge %0d got q=%b p=%b c=%0d want q=%0d p=1 c=0",
                 i, q, pulse, count, i % 2);
      end
    end
    t = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({q, pulse, count} !== {1'b1, 1'b0, 8'd0}) begin
        n_err++;
        $display("[TB] FAIL div0_hold cycle %0d got q=%b p=%b c=%0d want q=1 p=0 c=0",
                 i, q, pulse, count);
      end
      n_cmp++;
      if ({q, pulse, count, phase} !== model_vec()) begin
        n_err++;
        $display("[TB] FAIL div0_hold_model cycle %0d got %h want %h", i, {q, pulse, count, phase}, model_vec());
      end
    end
  endtask

  task automatic test_div_change();
    int toggles;
    reset = 1'b0; t = 1'b0; div = 8'd5;
    tick();
    reset = 1'b1; t = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 2) div = 8'd1;
      toggles = (k < 6) ? 0 : 1 + (k - 6) / 2;
      n_cmp++;
      if (q !== 1'(toggles % 2)) begin
        n_err++;
        $display("[TB] FAIL div_change_q edge %0d got %b want %0d", k, q, toggles % 2);
      end
      n_cmp++;
      if ({q, pulse, count, phase} !== model_vec()) begin
        n_err++;
        $display("[TB] FAIL div_change_model edge %0d got %h want %h", k, {q, pulse, count, phase}, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; t = 1'b0; div = 8'd5;
    tick();
    reset = 1'b1; t = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if ({q, count} !== {1'b1, 8'd4}) begin
      n_err++;
      $display("[TB] FAIL mid_setup got q=%b c=%0d want q=1 c=4", q, count);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({q, pulse, count} !== 10'd0) begin
      n_err++;
      $display("[TB] FAIL mid_reset got q=%b p=%b c=%0d want 0 0 0", q, pulse, count);
    end
`ifdef T_FF_DIVIDER_PHASE_EN
    n_cmp++;
    if (phase !== 4'b0001) begin
      n_err++;
      $display("[TB] FAIL mid_reset_phase got %b want 0001", phase);
    end
`endif
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if ({q, pulse, count} !== {1'b0, 1'b0, 8'(k)}) begin
        n_err++;
        $display("[TB] FAIL mid_resume edge %0d got q=%b p=%b c=%0d want q=0 p=0 c=%0d", k, q, pulse, count, k);
      end
    end
  endtask

  task automatic test_phase();
    reset = 1'b0; t = 1'b0; div = 8'd7;
    tick();
    reset = 1'b1; t = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      n_cmp++;
      if ({q, pulse, count, phase} !== model_vec()) begin
        n_err++;
        $display("[TB] FAIL phase_model edge %0d got %h want %h", i, {q, pulse, count, phase}, model_vec());
      end
    end
  endtask

  task automatic test_random();
    reset = 1'b0; t = 1'b0; div = 8'($urandom_range(0, 15));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 9) < 7);
      div = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      reset = ($urandom_range(0, 39) != 0);
      tick();
      n_cmp++;
      if ({q, pulse, count, phase} !== model_vec()) begin
        n_err++;
        $display("[TB] FAIL random_model step %0d got %h want %h", i, {q, pulse, count, phase}, model_vec());
      end
    end
  endtask

  task automatic test_width4_max();
    reset4 = 1'b0; t4 = 1'b0; div4 = 4'd15;
    tick();
    reset4 = 1'b1; t4 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_cmp++;
      if ({q4, pulse4, count4} !== {1'((i / 16) % 2), (i % 16 == 0), 4'(i % 16)}) begin
        n_err++;
        $display("[TB] FAIL width4_max edge %0d got q=%b p=%b c=%0d want q=%0d p=%0d c=%0d",
                 i, q4, pulse4, count4, (i / 16) % 2, (i % 16 == 0), i % 16);
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    reset = 1'b0; t = 1'b0; div = 8'd0;
    reset4 = 1'b0; t4 = 1'b0; div4 = 4'd15;
    test_reset();
    test_div3();
    test_div0_hold();
    test_div_change();
    test_reset_mid();
    test_phase();
    test_random();
    test_width4_max();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/t_ff_divider.md
# t_ff_divider

Parametrised successor to the single toggle flip-flop: a fully synchronous, enable-gated programmable toggle divider. It generates a divided square wave `q`, a one-cycle `pulse` strobe on every toggle, and an optional one-of-four phase indicator. The phase indicator is a synchronous replacement for gating the toggle output with the clock. The block sits wherever the design needs a slow clock-enable or a quadrant strobe derived from `clk` without creating a new clock net.

## Interface
Parameters:
- `WIDTH`, default 8: width of the divisor and the internal counter; minimum 2.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `t` input 1: toggle enable. When 0, all state holds.
- `div` input WIDTH: half-period minus one, in enabled cycles. Sampled only at reset and at each wrap.
- `q` output 1: divided square wave, registered.
- `pulse` output 1: registered strobe, high for exactly one cycle after each `q` toggle.
- `count` output WIDTH: current counter value, registered.
- `phase` output 4: one-hot quadrant of the current `q` period. Derived combinationally from registers; see Configuration.

## Operation
- Internal state: `cnt[WIDTH-1:0]`, `div_r[WIDTH-1:0]`, `q`, `pulse`.
- Reset (`reset`==0 at the edge): `cnt`=0, `q`=0, `pulse`=0, `div_r`<=`div`. `reset` has priority over `t`.
- `t`==1 and `cnt`!=`div_r`: `cnt`<=`cnt`+1, `pulse`<=0.
- `t`==1 and `cnt`==`div_r` (wrap): `cnt`<=0, `q`<=~`q`, `pulse`<=1, `div_r`<=`div`.
- `t`==0: `cnt`, `q` and `div_r` hold; `pulse`<=0. A strobe never lasts more than one cycle, even if `t` drops right after a wrap.
- `count` = `cnt`.
- Changes on `div` take effect only at the next wrap or reset. Mid-half-period changes never shorten or stretch the current half-period.
- `div`=0: `q` toggles on every enabled cycle and `pulse` stays high while `t`=1.
- `cnt` never exceeds `div_r`, so there is no counter overflow or wrap past all-ones. `div`=2^WIDTH-1 is legal and gives a half-period of 2^WIDTH cycles.
- Phase, with macro enabled: `upper` = (`cnt` > (`div_r` >> 1)), `idx` = {`q`, `upper`}, `phase` = 1 << `idx`. This gives: `q`=0 lower half → 4'b0001, `q`=0 upper → 4'b0010, `q`=1 lower → 4'b0100, `q`=1 upper → 4'b1000.
- Exactly one `phase` bit is high at all times while the macro is enabled. It holds while `t`=0.

## Timing
- Reset values: `q`=0, `pulse`=0, `count`=0, `phase`=4'b0001 with the macro enabled (4'b0000 without).
- With `t` held high, the full `q` period is 2·(`div_r`+1) cycles. The first toggle happens `div_r`+1 enabled edges after reset release.
- `pulse` rises on the same edge as the `q` toggle and falls on the next edge.
- `phase` changes in the same cycle as the `cnt`/`q` update; there is no extra latency.
- Reset asserted mid-period: on the next edge, state returns to reset values and `div_r` reloads. There is no partial strobe.
- `reset` deasserted and `t`=1 on the same edge: counting starts from that edge, with `cnt`=0 sampled beforehand.

## Configuration
- Macro: `T_FF_DIVIDER_PHASE_EN`.
- Defined: the `phase` logic described above is compiled in.
- Undefined: `phase` is tied to 4'b0000 and no comparator is synthesised. `q`, `pulse` and `count` are bit-identical in both builds.

## Test plan
- WIDTH=8, `div`=3, `t`=1 after reset release → `q` toggles every 4 cycles (period 8); `pulse` is high one cycle on each toggle; `count` sequences 0,1,2,3,0.
- `div`=0, `t`=1 → `q` alternates every cycle, `pulse` stays 1. Drop `t` for 3 cycles → `q` holds, `pulse`=0, `count`=0.
- `div`=5; change `div` to 1 when `count`=2 → current half-period stays 6 cycles; following half-periods are 2 cycles.
- Assert `reset`=0 when `count`=4, `q`=1, with `t`=1 still high → next edge gives `q`=0, `count`=0, `pulse`=0 (and `phase`=4'b0001 with the macro enabled); counting resumes after release.
- Macro defined, `div`=7 → `phase` steps 0001 (count 0–3), 0010 (4–7), 0100, 1000 and repeats every 16 cycles. Macro undefined: same stimulus gives `phase`=0000 with identical `q`/`pulse`.
- WIDTH=4, `div`=15 → half-period is 16 cycles, `count` reaches 15 then returns to 0 with no overflow.
